// File: rtl/vga_pkg.sv
// Shared screen geometry, phase encoding and rectangle test
// for the multi-target shooting game controller.
package vga_pkg;

  localparam logic [11:0] START_BTN_X = 12'd412;
  localparam logic [11:0] START_BTN_Y = 12'd334;
  localparam logic [11:0] START_BTN_W = 12'd200;
  localparam logic [11:0] START_BTN_H = 12'd100;
  localparam logic [11:0] DUCK_WIDTH  = 12'd64;
  localparam logic [11:0] DUCK_HEIGHT = 12'd48;

  typedef enum logic [1:0] {
    START_SCREEN = 2'd0,
    GAME         = 2'd1,
    GAME_END     = 2'd2
  } phase_e;

  // Widened by one bit so a box touching the right/bottom edge never wraps
  function automatic logic in_box(
    input logic [11:0] px,
    input logic [11:0] py,
    input logic [11:0] bx,
    input logic [11:0] by,
    input logic [11:0] bw,
    input logic [11:0] bh
  );
    logic [12:0] x0, x1, y0, y1;
    x0 = {1'b0, bx};
    y0 = {1'b0, by};
    x1 = x0 + {1'b0, bw} - 13'd1;
    y1 = y0 + {1'b0, bh} - 13'd1;
    return ({1'b0, px} >= x0) && ({1'b0, px} <= x1) &&
           ({1'b0, py} >= y0) && ({1'b0, py} <= y1);
  endfunction

endpackage

// File: rtl/magazine_ctl.sv
// Magazine and reserve bookkeeping: shot decrement, reload
// countdown and the reserve-to-magazine transfer.
module magazine_ctl
  import vga_pkg::*;
#(
  parameter int MAG_SIZE      = 3,
  parameter int TOTAL_BULLETS = 30,
  parameter int RELOAD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       shot,
  input  logic       reload_req,
  output logic [2:0] mag,
  output logic [6:0] reserve,
  output logic       reloading,
  output logic       reload_start
);

  localparam int CW = $clog2(RELOAD_CYCLES + 1);
  localparam logic [2:0] MAG_FULL = 3'(MAG_SIZE);

  logic [2:0]    mag_q, mag_d;
  logic [6:0]    res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    room, take;

  always_comb begin
    room  = MAG_FULL - mag_q;
    take  = ({4'd0, room} < res_q) ? room : res_q[2:0];
    reloading    = cnt_q != '0;
    reload_start = reload_req && !reloading &&
                   (mag_q < MAG_FULL) && (res_q != '0);
    mag_d = mag_q;
    res_d = res_q;
    cnt_d = cnt_q;
    if (load) begin
      mag_d = MAG_FULL;
      res_d = 7'(TOTAL_BULLETS);
      cnt_d = '0;
    end else if (reload_start) begin
      cnt_d = CW'(RELOAD_CYCLES);
    end else if (reloading) begin
      cnt_d = cnt_q - CW'(1);
      // Last countdown clock moves the whole top-up at once
      if (cnt_q == CW'(1)) begin
        mag_d = mag_q + take;
        res_d = res_q - {4'd0, take};
      end
    end else if (shot && mag_q != '0) begin
      mag_d = mag_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      mag_q <= mag_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
    end
  end

  assign mag     = mag_q;
  assign reserve = res_q;

endmodule

// File: rtl/multi_target_game_ctl.sv
// Game phase FSM, hit detection and scoring for several targets.
// Define ENEMY_SCORE_EN to count target escapes into enemy_score.
module multi_target_game_ctl
  import vga_pkg::*;
#(
  parameter int NUM_TARGETS   = 2,
  parameter int MAG_SIZE      = 3,
  parameter int TOTAL_BULLETS = 30,
  parameter int SCORE_W       = 7,
  parameter int RELOAD_CYCLES = 16,
  parameter int HUNT_DELAY    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [11:0]                  mouse_xpos,
  input  logic [11:0]                  mouse_ypos,
  input  logic                         left_mouse,
  input  logic                         right_mouse,
  input  logic [NUM_TARGETS-1:0][11:0] target_xpos,
  input  logic [NUM_TARGETS-1:0][11:0] target_ypos,
  input  logic [NUM_TARGETS-1:0]       target_active,
  input  logic [NUM_TARGETS-1:0]       target_escaped,
  output logic                         start_screen_enable,
  output logic                         game_enable,
  output logic                         game_end_enable,
  output logic                         hunt_start,
  output logic [NUM_TARGETS-1:0]       target_killed,
  output logic [SCORE_W-1:0]           my_score,
  output logic [SCORE_W-1:0]           enemy_score,
  output logic [2:0]                   bullets_in_magazine,
  output logic [6:0]                   bullets_left,
  output logic                         show_reload_char
);

  localparam int HW = $clog2(HUNT_DELAY + 1);

  phase_e                 state_q, state_d;
  logic                   left_q, right_q;
  logic                   left_edge, right_edge;
  logic [HW-1:0]          hunt_q, hunt_d;
  logic [NUM_TARGETS-1:0] hit, kill_q, kill_d;
  logic [SCORE_W-1:0]     my_q, my_d;
  logic                   flag_q, flag_d;
  logic                   in_game, enter_game, shot, reload_req;
  logic                   reloading, reload_start;
  logic [2:0]             mag;
  logic [6:0]             reserve;

  always_comb begin
    left_edge  = left_mouse && !left_q;
    right_edge = right_mouse && !right_q;
    in_game    = state_q == GAME;
    hunt_start = in_game && (hunt_q == HW'(HUNT_DELAY));
    enter_game = (state_q == START_SCREEN) && left_edge &&
                 in_box(mouse_xpos, mouse_ypos, START_BTN_X,
                        START_BTN_Y, START_BTN_W, START_BTN_H);
    shot       = in_game && left_edge && hunt_start &&
                 !reloading && (mag != '0);
    // A simultaneous left click wins; the reload request is dropped
    reload_req = in_game && right_edge && !left_edge;

    for (int i = 0; i < NUM_TARGETS; i++) begin
      hit[i] = target_active[i] &&
               in_box(mouse_xpos, mouse_ypos, target_xpos[i],
                      target_ypos[i], DUCK_WIDTH, DUCK_HEIGHT);
    end
    kill_d = shot ? (hit & (~hit + NUM_TARGETS'(1))) : '0;

    state_d = state_q;
    unique case (state_q)
      START_SCREEN: if (enter_game) state_d = GAME;
      GAME: if (mag == '0 && reserve == '0 && !reloading)
              state_d = GAME_END;
      GAME_END: if (left_edge) state_d = START_SCREEN;
      default: state_d = START_SCREEN;
    endcase

    hunt_d = hunt_q;
    if (enter_game) hunt_d = '0;
    else if (in_game && hunt_q != HW'(HUNT_DELAY)) hunt_d = hunt_q + HW'(1);

    my_d = my_q;
    if (enter_game) my_d = '0;
    else if (shot && hit != '0 && my_q != '1) my_d = my_q + SCORE_W'(1);

    flag_d = flag_q;
    if (enter_game || reload_start) flag_d = 1'b0;
    else if (in_game && left_edge && !reloading && mag == '0) flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= START_SCREEN;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      hunt_q  <= '0;
      kill_q  <= '0;
      my_q    <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_mouse;
      right_q <= right_mouse;
      hunt_q  <= hunt_d;
      kill_q  <= kill_d;
      my_q    <= my_d;
      flag_q  <= flag_d;
    end
  end

  magazine_ctl #(
    .MAG_SIZE      (MAG_SIZE),
    .TOTAL_BULLETS (TOTAL_BULLETS),
    .RELOAD_CYCLES (RELOAD_CYCLES)
  ) u_mag (
    .clk          (clk),
    .rst          (rst),
    .load         (enter_game),
    .shot         (shot),
    .reload_req   (reload_req),
    .mag          (mag),
    .reserve      (reserve),
    .reloading    (reloading),
    .reload_start (reload_start)
  );

`ifdef ENEMY_SCORE_EN
  logic [SCORE_W-1:0] en_q, en_d;
  logic [SCORE_W+3:0] esc_sum;

  always_comb begin
    esc_sum = {4'd0, en_q};
    for (int i = 0; i < NUM_TARGETS; i++) begin
      esc_sum = esc_sum + {{(SCORE_W+3){1'b0}}, target_escaped[i]};
    end
    en_d = en_q;
    if (enter_game) en_d = '0;
    else if (in_game)
      en_d = (esc_sum > {4'd0, {SCORE_W{1'b1}}}) ? '1 : esc_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) en_q <= '0;
    else     en_q <= en_d;
  end

  assign enemy_score = en_q;
`else
  logic unused_escaped;
  assign unused_escaped = ^target_escaped;
  assign enemy_score    = '0;
`endif

  assign start_screen_enable = state_q == START_SCREEN;
  assign game_enable         = state_q == GAME;
  assign game_end_enable     = state_q == GAME_END;
  assign target_killed       = kill_q;
  assign my_score            = my_q;
  assign bullets_in_magazine = mag;
  assign bullets_left        = reserve;
  assign show_reload_char    = flag_q;

endmodule
